// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning an 8:1 data mux and presenting the granted
// requester's data on a single valid/ready channel, with per-grant burst cap.

module mux_8_1 #(
    parameter int unsigned N = 32
) (
    input  logic [7:0][N-1:0] in_data,
    input  logic [2:0]        sel,
    output logic [N-1:0]      out_data
);
    assign out_data = in_data[sel];
endmodule

module rr_mux_arbiter #(
    parameter int unsigned N         = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        req,
    input  logic [7:0][N-1:0] in_data,
    output logic [7:0]        grant,
    output logic [2:0]        select,
    output logic [N-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        ack
);
    localparam int unsigned CNT_W      = 4;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [7:0]       grant_d;
    logic [2:0]       select_d;
    logic [2:0]       last_owner, last_d;
    logic [CNT_W-1:0] burst_cnt, burst_d;

    logic [7:0] owner_oh;
    logic [7:0] others;
    logic       xfer;
    logic [2:0] pick_idle, pick_rel, pick_oth;

    // First set bit of mask scanning cyclically from last+1; last itself is lowest priority.
    function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] last);
        logic [2:0] idx;
        rr_pick = last;
        for (int k = 8; k >= 1; k--) begin
            idx = last + 3'(k);
            if (mask[idx]) rr_pick = idx;
        end
    endfunction

    mux_8_1 #(.N(N)) u_mux (
        .in_data  (in_data),
        .sel      (select),
        .out_data (out_data)
    );

    assign out_valid = |(grant & req);
    assign ack       = grant & req & {8{out_valid & out_ready}};
    assign xfer      = out_valid & out_ready;
    assign owner_oh  = 8'(1) << select;
    assign others    = req & ~owner_oh;
    assign pick_idle = rr_pick(req, last_owner);
    assign pick_rel  = rr_pick(req, select);
    assign pick_oth  = rr_pick(others, select);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant      <= '0;
            select     <= '0;
            last_owner <= 3'd7;
            burst_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            grant      <= grant_d;
            select     <= select_d;
            last_owner <= last_d;
            burst_cnt  <= burst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant;
        select_d = select;
        last_d   = last_owner;
        burst_d  = burst_cnt;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d  = 8'(1) << pick_idle;
                    select_d = pick_idle;
                    burst_d  = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (!req[select]) begin
                    // Owner withdrew: hand over in the same edge, no idle bubble.
                    last_d  = select;
                    burst_d = '0;
                    if (|req) begin
                        grant_d  = 8'(1) << pick_rel;
                        select_d = pick_rel;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    if (burst_cnt == BURST_LAST) begin
                        burst_d = '0;
                        if (|others) begin
                            last_d   = select;
                            grant_d  = 8'(1) << pick_oth;
                            select_d = pick_oth;
                        end
                    end else begin
                        burst_d = burst_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus randomized traffic,
// all checked against an integer-level round-robin model.

module tb_rr_mux_arbiter;
    localparam int unsigned N  = 32;
    localparam int unsigned MB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        req;
    logic [7:0][N-1:0] in_data;
    logic [7:0]        grant;
    logic [2:0]        select;
    logic [N-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        ack;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner index (-1 when idle), last owner, shown select, burst count.
    int m_owner, m_last, m_sel, m_cnt;
    bit fix3 = 1'b0;

    rr_mux_arbiter #(.N(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
        .grant     (grant),
        .select    (select),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_winner(input logic [7:0] m, input int last);
        int idx;
        for (int k = 1; k <= 8; k++) begin
            idx = (last + k) % 8;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] onehot(input int i);
        return (i < 0) ? 8'h00 : (8'(1) << i);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_sel   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rdy);
        logic [7:0] oth;
        if (m_owner < 0) begin
            m_owner = rr_winner(r, m_last);
            m_cnt   = 0;
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = rr_winner(r, m_last);
            m_cnt   = 0;
        end else if (rdy) begin
            if (m_cnt == MB - 1) begin
                oth   = r & ~onehot(m_owner);
                m_cnt = 0;
                if (oth != 0) begin
                    m_last  = m_owner;
                    m_owner = rr_winner(oth, m_last);
                end
            end else begin
                m_cnt++;
            end
        end
        if (m_owner >= 0) m_sel = m_owner;
    endtask

    task automatic check_outputs(input string pfx);
        logic vld;
        vld = (m_owner >= 0) && req[m_owner];
        check({pfx, "_grant"}, 64'(grant), 64'(onehot(m_owner)));
        check({pfx, "_select"}, 64'(select), 64'(m_sel));
        check({pfx, "_valid"}, 64'(out_valid), 64'(vld));
        check({pfx, "_ack"}, 64'(ack), 64'((vld && out_ready) ? onehot(m_owner) : 8'h00));
        check({pfx, "_data"}, 64'(out_data), 64'(in_data[m_sel]));
    endtask

    // One clock: drive inputs, check combinational view, advance model, check registered view.
    task automatic cycle(input logic [7:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        for (int i = 0; i < 8; i++) in_data[i] = $urandom;
        if (fix3) in_data[3] = 32'hDEADBEEF;
        #1;
        check_outputs("pre");
        model_step(r, rdy);
        @(posedge clk);
        #1;
        check_outputs("post");
    endtask

    initial begin
        logic [7:0] r;
        logic       rdy;

        // Reset held with everyone requesting.
        rst_n     = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_data[i] = $urandom;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_grant", 64'(grant), 64'(8'h00));
            check("rst_select", 64'(select), 64'(3'd0));
            check("rst_valid", 64'(out_valid), 64'(1'b0));
            check("rst_ack", 64'(ack), 64'(8'h00));
        end
        rst_n = 1'b1;
        cycle(8'hFF, 1'b1);
        check("rst_rel_grant", 64'(grant), 64'(8'h01));

        // Single requester keeps ownership past the burst cap.
        fix3 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle(8'h08, 1'b1);
            if (c > 0) begin
                check("single_grant", 64'(grant), 64'(8'h08));
                check("single_select", 64'(select), 64'(3'd3));
                check("single_data", 64'(out_data), 64'(32'hDEADBEEF));
                check("single_ack", 64'(ack), 64'(8'h08));
            end
        end
        fix3 = 1'b0;

        // Fair rotation between 1 and 5: owner 3 withdraws, 5 wins first, bursts of MB.
        for (int c = 0; c < 24; c++) begin
            cycle(8'h22, 1'b1);
            check("rot_ack", 64'(ack), 64'(((c / MB) % 2 == 0) ? 8'h20 : 8'h02));
            check("rot_valid", 64'(out_valid), 64'(1'b1));
        end

        // Backpressure: owner 2 reaches count 2, stalls 10 cycles, then finishes its burst.
        cycle(8'h04, 1'b1);
        cycle(8'h04, 1'b1);
        cycle(8'h04, 1'b1);
        for (int c = 0; c < 10; c++) begin
            cycle(8'hFF, 1'b0);
            check("bp_grant", 64'(grant), 64'(8'h04));
            check("bp_ack", 64'(ack), 64'(8'h00));
        end
        cycle(8'hFF, 1'b1);
        check("bp_resume", 64'(grant), 64'(8'h04));
        cycle(8'hFF, 1'b1);
        check("bp_switch", 64'(grant), 64'(8'h08));

        // Wrap from owner 7 to 0 on withdrawal, then drain to idle.
        cycle(8'h80, 1'b1);
        check("wrap_own7", 64'(grant), 64'(8'h80));
        cycle(8'h01, 1'b1);
        check("wrap_grant", 64'(grant), 64'(8'h01));
        check("wrap_select", 64'(select), 64'(3'd0));
        cycle(8'h00, 1'b1);
        check("idle_grant", 64'(grant), 64'(8'h00));
        check("idle_valid", 64'(out_valid), 64'(1'b0));

        // Reset mid-burst: owner 4 at count 2, reset between edges.
        cycle(8'h10, 1'b1);
        cycle(8'h10, 1'b1);
        cycle(8'h10, 1'b1);
        check("mid_ack_before", 64'(ack), 64'(8'h10));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", 64'(grant), 64'(8'h00));
        check("mid_rst_ack", 64'(ack), 64'(8'h00));
        check("mid_rst_valid", 64'(out_valid), 64'(1'b0));
        model_reset();
        #1;
        rst_n = 1'b1;
        cycle(8'h30, 1'b1);
        check("mid_rel_grant", 64'(grant), 64'(8'h10));

        // Randomized traffic with occasional owner withdrawal and asynchronous reset.
        r = 8'h00;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(3) == 0) r = 8'($urandom);
            if ($urandom_range(7) == 0) r = r & ~onehot(m_owner);
            rdy = ($urandom_range(9) < 7);
            cycle(r, rdy);
            if ($urandom_range(63) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rnd_rst_grant", 64'(grant), 64'(8'h00));
                check("rnd_rst_ack", 64'(ack), 64'(8'h00));
                model_reset();
                #1;
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
